// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction
// memory (one-cycle read latency), and presents {pc, instr} pairs to decode.
// A one-entry hold buffer keeps read data that decode could not accept,
// because the memory shows each read word for a single cycle only.
//
// Handshake: outValid/outReady follow strict valid/ready rules. A transfer
// happens on a rising edge where outValid and outReady are both 1. Once
// outValid is 1, outPc/outInstr stay stable until that transfer or until a
// redirect. In a redirect cycle nothing is transferred, whatever outReady is.
module instr_fetch #(
    parameter int                   addrWidth   = 32,
    parameter int                   instrWidth  = 32,
    parameter logic [addrWidth-1:0] resetVector = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic [addrWidth-1:0]  imemAddr,
    input  logic [instrWidth-1:0] imemInstr,
    input  logic                  redirectValid,
    input  logic [addrWidth-1:0]  redirectTarget,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [addrWidth-1:0]  outPc,
    output logic [instrWidth-1:0] outInstr
);

    logic [addrWidth-1:0]  pc;
    logic                  reqValid;   // read issued last cycle, data on imemInstr now
    logic [addrWidth-1:0]  reqPc;
    logic                  holdValid;  // stalled read data parked in the hold buffer
    logic [addrWidth-1:0]  holdPc;
    logic [instrWidth-1:0] holdInstr;

    logic issue;    // present a new address this cycle
    logic capture;  // in-flight read data must be parked in the hold buffer
    logic drain;    // hold buffer is consumed by decode this cycle

    // Output muxing and per-cycle control decisions.
    always_comb begin
        outValid = reqValid | holdValid;
        issue    = (!outValid | outReady) & !redirectValid;
        capture  = reqValid & !outReady & !redirectValid;
        drain    = holdValid & outReady & !redirectValid;
        imemAddr = pc;
        outPc    = holdValid ? holdPc    : reqPc;
        outInstr = holdValid ? holdInstr : imemInstr;
    end

    // PC and valid flags; a redirect overrides issue, capture and drain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= resetVector;
            reqValid  <= 1'b0;
            holdValid <= 1'b0;
        end else if (redirectValid) begin
            pc        <= redirectTarget & ~addrWidth'(3);
            reqValid  <= 1'b0;
            holdValid <= 1'b0;
        end else begin
            if (issue) begin
                pc       <= pc + addrWidth'(4);
                reqValid <= 1'b1;
            end else if (capture) begin
                reqValid <= 1'b0;
            end
            if (capture) begin
                holdValid <= 1'b1;
            end else if (drain) begin
                holdValid <= 1'b0;
            end
        end
    end

    // Payload registers; they are qualified by the valid flags and need no reset.
    always_ff @(posedge clock) begin
        if (issue) begin
            reqPc <= pc;
        end
        if (capture) begin
            holdPc    <= reqPc;
            holdInstr <= imemInstr;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed steps plus a randomized
// ready/redirect phase, checked against an in-order expected-PC scoreboard.
module tb_instr_fetch;

    localparam logic [31:0] MASK = 32'hA5A5_0000;

    // clock / reset and DUT wiring
    logic        clock          = 1'b0;
    logic        reset_n        = 1'b0;
    logic [31:0] imemAddr;
    logic [31:0] imemInstr;
    logic        redirectValid  = 1'b0;
    logic [31:0] redirectTarget = 32'h0;
    logic        outValid;
    logic        outReady       = 1'b1;
    logic [31:0] outPc;
    logic [31:0] outInstr;

    always #5 clock = ~clock;

    instr_fetch #(
        .addrWidth  (32),
        .instrWidth (32),
        .resetVector(32'h0000_0000)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .imemAddr      (imemAddr),
        .imemInstr     (imemInstr),
        .redirectValid (redirectValid),
        .redirectTarget(redirectTarget),
        .outValid      (outValid),
        .outReady      (outReady),
        .outPc         (outPc),
        .outInstr      (outInstr)
    );

    // synchronous memory model: word at address A reads back as A ^ MASK
    always @(posedge clock) imemInstr <= imemAddr ^ MASK;

    // scoreboard state
    int          n_cmp     = 0;
    int          n_err     = 0;
    int          delivered = 0;
    logic [31:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected stream restarts at an aligned address after reset or redirect
    task automatic restart(input logic [31:0] start);
        exp_q.delete();
        exp_q.push_back({start[31:2], 2'b00});
    endtask

    // monitor: accepted transfers in order, stability while stalled, invariant
    always @(negedge clock) begin
        logic [31:0] nxt;
        if (reset_n) begin
            check("inv_req_hold", {63'b0, dut.reqValid & dut.holdValid}, 64'd0);
            if (prev_stall) begin
                check("stable_valid", {63'b0, outValid}, 64'd1);
                check("stable_pc", {32'b0, outPc}, {32'b0, prev_pc});
                check("stable_instr", {32'b0, outInstr}, {32'b0, prev_instr});
            end
            if (outValid && outReady && !redirectValid) begin
                check("seq_pc", {32'b0, outPc}, {32'b0, exp_q[0]});
                check("seq_instr", {32'b0, outInstr}, {32'b0, exp_q[0] ^ MASK});
                nxt = exp_q.pop_front() + 32'd4;
                exp_q.push_back(nxt);
                delivered++;
            end
            prev_stall = outValid && !outReady && !redirectValid;
            prev_pc    = outPc;
            prev_instr = outInstr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // driver: advance to just after the next rising edge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int start_cnt;
        int cycles;

        // reset state
        repeat (2) @(negedge clock);
        check("rst_valid", {63'b0, outValid}, 64'd0);
        check("rst_addr", {32'b0, imemAddr}, 64'd0);

        // release reset, continuous ready
        cyc();
        reset_n = 1'b1;
        restart(32'h0);
        @(negedge clock);
        check("first_valid_pre", {63'b0, outValid}, 64'd0);
        cyc();
        @(negedge clock);
        check("first_valid", {63'b0, outValid}, 64'd1);
        check("first_pc", {32'b0, outPc}, 64'h0);
        cyc();
        @(negedge clock);
        check("second_pc", {32'b0, outPc}, 64'h4);

        // stall three cycles while presenting 0x8
        cyc();
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_valid", {63'b0, outValid}, 64'd1);
            check("stall_pc", {32'b0, outPc}, 64'h8);
            check("stall_instr", {32'b0, outInstr}, {32'b0, 32'h8 ^ MASK});
            check("stall_addr", {32'b0, imemAddr}, 64'hC);
            if (i < 2) cyc();
        end
        cyc();
        outReady = 1'b1;
        @(negedge clock);
        check("drain_pc", {32'b0, outPc}, 64'h8);
        cyc();
        @(negedge clock);
        check("after_drain_pc", {32'b0, outPc}, 64'hC);

        // redirect to 0x103 while the hold buffer is full
        cyc();
        outReady = 1'b0;
        cyc();
        check("hold_full", {63'b0, dut.holdValid}, 64'd1);
        redirectValid  = 1'b1;
        redirectTarget = 32'h0000_0103;
        outReady       = 1'b1;
        cyc();
        redirectValid = 1'b0;
        restart(32'h0000_0103);
        @(negedge clock);
        check("rd_gap_valid", {63'b0, outValid}, 64'd0);
        cyc();
        @(negedge clock);
        check("rd_valid", {63'b0, outValid}, 64'd1);
        check("rd_pc", {32'b0, outPc}, 64'h100);
        cyc();
        @(negedge clock);
        check("rd_pc2", {32'b0, outPc}, 64'h104);

        // PC wrap at the top of the address space
        cyc();
        redirectValid  = 1'b1;
        redirectTarget = 32'hFFFF_FFF8;
        cyc();
        redirectValid = 1'b0;
        restart(32'hFFFF_FFF8);
        cyc();
        @(negedge clock);
        check("wrap_pc0", {32'b0, outPc}, 64'hFFFF_FFF8);
        cyc();
        @(negedge clock);
        check("wrap_pc1", {32'b0, outPc}, 64'hFFFF_FFFC);
        cyc();
        @(negedge clock);
        check("wrap_pc2", {32'b0, outPc}, 64'h0);

        // random ready (50%) with occasional random redirects
        start_cnt = delivered;
        cycles    = 0;
        while ((delivered - start_cnt) < 1000 && cycles < 8000) begin
            cyc();
            if (redirectValid) restart(redirectTarget);
            outReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                redirectValid  = 1'b1;
                redirectTarget = $urandom;
            end else begin
                redirectValid = 1'b0;
            end
            cycles++;
        end
        cyc();
        if (redirectValid) restart(redirectTarget);
        redirectValid = 1'b0;
        outReady      = 1'b1;
        check("rand_delivered", {63'b0, (delivered - start_cnt) >= 1000}, 64'd1);
        repeat (3) cyc();

        // asynchronous reset in the middle of a stall
        outReady = 1'b0;
        cyc();
        cyc();
        #2;
        check("pre_rst_valid", {63'b0, outValid}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", {63'b0, outValid}, 64'd0);
        check("async_rst_addr", {32'b0, imemAddr}, 64'h0);
        @(negedge clock);
        cyc();
        reset_n  = 1'b1;
        outReady = 1'b1;
        restart(32'h0);
        @(negedge clock);
        check("rerst_valid_pre", {63'b0, outValid}, 64'd0);
        cyc();
        @(negedge clock);
        check("rerst_pc", {32'b0, outPc}, 64'h0);
        cyc();
        @(negedge clock);
        check("rerst_pc2", {32'b0, outPc}, 64'h4);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Initiator side of the instruction-memory read port: owns the program counter, drives the word address into the synchronous, single-cycle-latency, always-enabled instruction memory, and delivers {pc, instr} pairs to decode over a valid/ready handshake.
- Absorbs back-pressure with a one-entry hold buffer, because memory read data is present for only one cycle.
- Accepts branch/jump redirects from execute.

Parameters:
addrWidth, 32, width of the PC and of the memory address
instrWidth, 32, width of an instruction word
resetVector, 32'h0000_0000, PC after reset; must be 4-byte aligned

Ports:
clock  input  1  sole clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
imemAddr  output  addrWidth  byte address to instruction memory; equals pc register (combinational)
imemInstr  input  instrWidth  memory read data; valid the cycle after the address was presented
redirectValid  input  1  flush and restart fetch at redirectTarget
redirectTarget  input  addrWidth  new PC; bits [1:0] ignored and forced to 0
outValid  output  1  {outPc, outInstr} valid
outReady  input  1  decode accepts this cycle
outPc  output  addrWidth  address of the presented instruction
outInstr  output  instrWidth  presented instruction

Behaviour:
- State:
  - pc
  - reqValid/reqPc: a request was issued last cycle, so its data is on imemInstr now
  - holdValid/holdPc/holdInstr
  - Invariant: reqValid and holdValid are never both 1.
- Reset (async assert, sync release):
  - pc=resetVector; reqValid=0; holdValid=0; outValid=0; imemAddr=resetVector.
  - Hold and req payload registers are not reset.
- Outputs:
  - outValid = reqValid | holdValid.
  - When holdValid: outPc=holdPc, outInstr=holdInstr.
  - Otherwise: outPc=reqPc, outInstr=imemInstr.
- Handshake:
  - fire = outValid & outReady.
  - Once outValid is 1, outPc and outInstr stay stable until fire or redirect.
- Issue rule: issue = (!outValid | outReady) & !redirectValid. On issue:
  - reqValid<=1, reqPc<=pc, pc<=pc+4.
  - Addition is modulo 2^addrWidth; 0xFFFF_FFFC wraps to 0.
- No issue:
  - pc holds, so imemAddr holds.
  - The redundant memory read is ignored.
- Stall capture: if reqValid & !outReady & !redirectValid, then holdValid<=1, holdPc<=reqPc, holdInstr<=imemInstr, reqValid<=0.
- Hold drain: if holdValid & outReady & !redirectValid, then holdValid<=0, and the same cycle issues the next request. There is no bubble.
- Throughput: with outReady held at 1, one instruction per cycle.
- First outValid=1 occurs 1 cycle after the first clock edge with reset_n high.
- Redirect (highest priority):
  - reqValid<=0, holdValid<=0, pc<={redirectTarget[addrWidth-1:2],2'b00}.
  - No issue in the redirect cycle.
  - outValid is not gated in the redirect cycle. Any instruction presented that cycle is discarded, even if outReady=1, and decode must not treat it as accepted.
  - Target issues the cycle after redirect; outValid for the target is 2 cycles after redirectValid was sampled.
  - Redirect on consecutive cycles: the last one wins.
- Reset mid-operation: all valids clear immediately (asynchronous); fetch resumes from resetVector.

Test Plan:
- Reset release, outReady=1, memory model returns addr^32'hA5A5_0000 -> outValid rises 1 cycle after release; outPc sequence 0x0,0x4,0x8,... one per cycle; outInstr matches the model.
- outReady dropped for 3 cycles while presenting pc 0x8 -> outPc=0x8 and outInstr stable all 3 cycles; imemAddr held at 0xC; after release 0x8 then 0xC delivered with no gap and no duplicate.
- redirectValid with target 0x103 while a hold is full -> hold and req flushed; next delivered outPc=0x100 exactly 2 cycles later, then 0x104.
- pc=0xFFFF_FFF8, continuous ready -> outPc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Random outReady (50%) over 1000 instructions with a scoreboard -> in-order, no loss or duplication; reqValid&holdValid never both 1 (assertion).
- reset_n pulsed low mid-stall -> outValid=0 asynchronously; after release outPc restarts at resetVector.
